// File: rtl/rc_pkg.sv
// ============================================================================
// Module  : rc_pkg
// Brief   : Shared FSM encoding and index-width helper for rc_adder_seq_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Chunk index width: a single-chunk sequencer still needs a 1-bit counter.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rc_adder_w_cin.sv
// ============================================================================
// Module  : rc_adder_w_cin
// Brief   : Width-bit ripple-carry adder slice with carry-in and carry-out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rc_adder_w_cin #(
    parameter int Width = 4
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             c_i,
    output logic [Width-1:0] s_o,
    output logic             c_o
);

    logic [Width:0] w_carry;

    assign w_carry[0] = c_i;

    for (genvar i = 0; i < Width; i++) begin : g_bit
        assign s_o[i]         = a_i[i] ^ b_i[i] ^ w_carry[i];
        assign w_carry[i + 1] = (a_i[i] & b_i[i]) | (w_carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = w_carry[Width];

endmodule

`default_nettype wire

// File: rtl/rc_adder_seq_ctrl.sv
// ============================================================================
// Module  : rc_adder_seq_ctrl
// Brief   : Multi-cycle wide adder reusing one Width-bit slice, LSB chunk first.
//           Optional subtract mode enabled by macro RC_SEQ_SUB_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rc_adder_seq_ctrl
    import rc_pkg::*;
#(
    parameter int Width  = 4,
    parameter int Chunks = 4,
    localparam int OpW   = Width * Chunks
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic [OpW-1:0] a_i,
    input  logic [OpW-1:0] b_i,
    input  logic           carry_i,
`ifdef RC_SEQ_SUB_EN
    input  logic           sub_i,
`endif
    output logic           valid_o,
    input  logic           ready_i,
    output logic [OpW-1:0] result_o,
    output logic           carry_o
);

    localparam int                IdxW    = idx_width(Chunks);
    localparam logic [IdxW-1:0]   LastIdx = IdxW'(Chunks - 1);

    state_e                         state_q;
    logic [IdxW-1:0]                idx_q;
    logic [IdxW-1:0]                idx_d;
    logic [Chunks-1:0][Width-1:0]   a_q;
    logic [Chunks-1:0][Width-1:0]   b_q;
    logic [Chunks-1:0][Width-1:0]   res_q;
    logic                           carry_q;
    logic                           carry_out_q;
    logic                           valid_q;
    logic                           ready_q;

    logic [Width-1:0]               w_a_chunk;
    logic [Width-1:0]               w_b_chunk;
    logic [Width-1:0]               w_sum;
    logic                           w_cout;
    logic                           w_cin_accept;

`ifdef RC_SEQ_SUB_EN
    logic                           sub_q;

    // Subtraction is a + ~b + 1; the +1 enters as the chunk-0 carry.
    assign w_b_chunk    = sub_q ? ~b_q[idx_q] : b_q[idx_q];
    assign w_cin_accept = sub_i ? 1'b1 : carry_i;
`else
    assign w_b_chunk    = b_q[idx_q];
    assign w_cin_accept = carry_i;
`endif

    assign w_a_chunk = a_q[idx_q];
    assign idx_d     = idx_q + IdxW'(1);

    rc_adder_w_cin #(
        .Width (Width)
    ) u_slice (
        .a_i (w_a_chunk),
        .b_i (w_b_chunk),
        .c_i (carry_q),
        .s_o (w_sum),
        .c_o (w_cout)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
`ifdef RC_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= w_cin_accept;
`ifdef RC_SEQ_SUB_EN
                        sub_q   <= sub_i;
`endif
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[idx_q] <= w_sum;
                    carry_q      <= w_cout;
                    // Index parks at 0 after the last chunk so it never walks past Chunks-1.
                    if (idx_q == LastIdx) begin
                        idx_q       <= '0;
                        carry_out_q <= w_cout;
                        valid_q     <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    idx_q   <= '0;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready_o  = ready_q;
    assign valid_o  = valid_q;
    assign result_o = res_q;
    assign carry_o  = carry_out_q;

endmodule

`default_nettype wire

// File: tb/tb_rc_adder_seq_ctrl.sv
// ============================================================================
// Module  : tb_rc_adder_seq_ctrl
// Brief   : Directed self-checking bench for rc_adder_seq_ctrl (Width=4, Chunks=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rc_adder_seq_ctrl;

    localparam int Width  = 4;
    localparam int Chunks = 4;
    localparam int OpW    = Width * Chunks;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           valid_i;
    logic           ready_o;
    logic [OpW-1:0] a_i;
    logic [OpW-1:0] b_i;
    logic           carry_i;
    logic           sub_i;
    logic           valid_o;
    logic           ready_i;
    logic [OpW-1:0] result_o;
    logic           carry_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    rc_adder_seq_ctrl #(
        .Width  (Width),
        .Chunks (Chunks)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .carry_i  (carry_i),
`ifdef RC_SEQ_SUB_EN
        .sub_i    (sub_i),
`endif
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .result_o (result_o),
        .carry_o  (carry_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one accept edge, then wait for valid_o within a bounded window.
    task automatic issue(input logic [OpW-1:0] a, input logic [OpW-1:0] b,
                         input logic cin, input logic sub, input string tag);
        int lat;
        a_i     = a;
        b_i     = b;
        carry_i = cin;
        sub_i   = sub;
        valid_i = 1'b1;
        chk({tag, "_ready_before"}, 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        a_i     = 16'hDEAD;
        b_i     = 16'hBEEF;
        chk({tag, "_ready_busy"}, 32'(ready_o), 32'd0);
        lat = 0;
        while (!valid_o && lat < 20) begin
            @(posedge clk_i);
            #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(Chunks));
    endtask

    task automatic op(input logic [OpW-1:0] a, input logic [OpW-1:0] b, input logic cin,
                      input logic sub, input logic [OpW-1:0] er, input logic ec,
                      input string tag);
        ready_i = 1'b1;
        issue(a, b, cin, sub, tag);
        chk({tag, "_result"}, 32'(result_o), 32'(er));
        chk({tag, "_carry"},  32'(carry_o),  32'(ec));
        @(posedge clk_i);
        #1;
        chk({tag, "_valid_drop"}, 32'(valid_o), 32'd0);
        chk({tag, "_ready_back"}, 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        carry_i = 1'b0;
        sub_i   = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_valid",  32'(valid_o),  32'd0);
        chk("rst_ready",  32'(ready_o),  32'd1);
        chk("rst_result", 32'(result_o), 32'd0);
        chk("rst_carry",  32'(carry_o),  32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        op(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, "add_ff_1");
        op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, "add_wrap");
        op(16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, "add_cin");
        op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "add_max");
        op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, "add_mix");

        // Backpressure: result held while consumer stalls and new operands are offered.
        ready_i = 1'b0;
        issue(16'h00FF, 16'h0001, 1'b0, 1'b0, "bp");
        valid_i = 1'b1;
        a_i     = 16'hAAAA;
        b_i     = 16'h1111;
        carry_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            chk("bp_valid_hold",  32'(valid_o),  32'd1);
            chk("bp_result_hold", 32'(result_o), 32'h0100);
            chk("bp_carry_hold",  32'(carry_o),  32'd0);
            chk("bp_ready_low",   32'(ready_o),  32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("bp_release_valid", 32'(valid_o), 32'd0);
        chk("bp_release_ready", 32'(ready_o), 32'd1);
        // valid_i is still high with the pending operands, so they are accepted now.
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        chk("bp_next_accept", 32'(ready_o), 32'd0);
        repeat (Chunks) @(posedge clk_i);
        #1;
        chk("bp_next_valid",  32'(valid_o),  32'd1);
        chk("bp_next_result", 32'(result_o), 32'hBBBB);
        @(posedge clk_i);
        #1;

        // Reset in the middle of RUN (index 2).
        ready_i = 1'b1;
        a_i     = 16'hFFFF;
        b_i     = 16'h0001;
        carry_i = 1'b0;
        valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_valid",  32'(valid_o),  32'd0);
        chk("mid_rst_ready",  32'(ready_o),  32'd1);
        chk("mid_rst_result", 32'(result_o), 32'd0);
        chk("mid_rst_carry",  32'(carry_o),  32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        op(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, "post_rst");

`ifdef RC_SEQ_SUB_EN
        op(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        op(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
        op(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, "sub_equal");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
